popcount_seq: RTL



---
 rtl/popcount_seq.sv | 68 ++++++
 1 files changed

// File: rtl/popcount_seq.sv
// popcount_seq: multi-cycle population counter, CHUNK bits per cycle, start/busy/done handshake.
// Defining POPCOUNT_ZERO_MODE_EN adds a `mode` input that counts '0' bits instead.
module popcount_seq #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4,
   localparam int NCYC = (WIDTH + CHUNK - 1) / CHUNK,
   localparam int CW = $clog2(WIDTH + 1),
   localparam int CCW = $clog2(NCYC + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] in_s,
`ifdef POPCOUNT_ZERO_MODE_EN
   input  logic             mode,
`endif
   output logic             busy,
   output logic             done,
   output logic [CW-1:0]    n_one
);
   localparam int SW = NCYC * CHUNK;
   localparam logic [CCW-1:0] LAST = CCW'(NCYC - 1);
   typedef enum logic {IDLE, RUN} state_t;
   state_t state, state_n;
   logic [SW-1:0] shreg;
   logic [CW-1:0] acc, pc, sum;
   logic [CCW-1:0] cyc;
   logic [WIDTH-1:0] src;
   logic load, fin;
`ifdef POPCOUNT_ZERO_MODE_EN
   // Inversion happens before zero-extension so pad bits never count.
   assign src = mode ? ~in_s : in_s;
`else
   assign src = in_s;
`endif
   always_comb begin
      pc = '0;
      for (int i = 0; i < CHUNK; i++) pc = pc + CW'(shreg[i]);
      sum = acc + pc;
      load = state == IDLE && start;
      fin = state == RUN && cyc == LAST;
      state_n = load ? RUN : fin ? IDLE : state;
      busy = state == RUN;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         shreg <= '0;
         acc <= '0;
         cyc <= '0;
         done <= 1'b0;
         n_one <= '0;
      end else begin
         state <= state_n;
         done <= fin;
         if (load) begin
            shreg <= SW'(src);
            acc <= '0;
            cyc <= '0;
         end else if (state == RUN) begin
            shreg <= shreg >> CHUNK;
            acc <= sum;
            cyc <= cyc + CCW'(1);
         end
         if (fin) n_one <= sum;
      end
   end
endmodule
